gcm_out_serializer: RTL and testbench

- Downstream stage of the gcm core. Captures each 128-bit output block (ciphertext/plaintext blocks, then the tag) on the core's store strobe.
- Buffers blocks in a small FIFO, because the gcm core cannot be back-pressured.
- Serializes blocks into a 32-bit AXI4-Stream master toward the DMA/AXI wrapper, asserting tlast on the final word of the tag block.

---
 rtl/gcm_pkg.sv | 18 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/gcm_out_serializer.sv | 145 ++++++++++++++
 tb/tb_gcm_out_serializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcm_pkg.sv
// Shared types and constants for the gcm output path: block/word widths,
// the serializer FSM encoding and the FIFO entry layout.
package gcm_pkg;

  localparam int GCM_BLK_BITS   = 128;
  localparam int AXIS_WORD_BITS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic                    last;
    logic [GCM_BLK_BITS-1:0] blk;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, full/empty flags and
// simultaneous push/pop; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_count_next
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data       = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/gcm_out_serializer.sv
// Captures gcm output blocks on the store strobe, buffers them (the core cannot stall)
// and emits them MS word first on an AXI4-Stream master, tlast on the tag's final word.
module gcm_out_serializer
  import gcm_pkg::*;
#(
  parameter  int BLK_BITS     = GCM_BLK_BITS,
  parameter  int WORD_BITS    = AXIS_WORD_BITS,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int AFULL_MARGIN = 1,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLK_BITS-1:0]  in_blk,
  input  logic                 in_store,
  input  logic                 in_last,
  output logic                 in_afull,
  output logic                 overflow,
  output logic [CW-1:0]        fifo_count,
  output logic [WORD_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int NWORDS = BLK_BITS / WORD_BITS;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int EW     = BLK_BITS + 1;

  state_t              r_state;
  logic [BLK_BITS-1:0] r_shift;
  logic                r_last;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tvalid;
  logic                r_tlast;
  logic                r_overflow;
  logic                r_afull;

  logic                w_hs;
  logic                w_final;
  logic                w_slot;
  logic                w_pop;
  logic                w_bypass;
  logic                w_load;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [EW-1:0]       w_head;
  logic [BLK_BITS-1:0] w_load_blk;
  logic                w_load_last;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_next;

  assign w_hs    = r_tvalid && m_axis_tready;
  assign w_final = w_hs && (r_cnt == CNT_W'(NWORDS - 1));

  // A new block may enter the shift register when idle or as the current one finishes;
  // the FIFO head always has priority so ordering is preserved.
  assign w_slot   = (r_state == IDLE) || w_final;
  assign w_pop    = w_slot && !w_empty;
  assign w_bypass = w_slot && w_empty && in_store;
  assign w_load   = w_pop || w_bypass;
  assign w_push   = in_store && !w_bypass;

  assign w_load_blk  = w_pop ? w_head[BLK_BITS-1:0] : in_blk;
  assign w_load_last = w_pop ? w_head[BLK_BITS]     : in_last;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_data       ({in_last, in_blk}),
    .i_pop        (w_pop),
    .o_data       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count),
    .o_count_next (w_count_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state  <= SEND;
            r_shift  <= w_load_blk;
            r_last   <= w_load_last;
            r_cnt    <= '0;
            r_tvalid <= 1'b1;
            r_tlast  <= w_load_last && (NWORDS == 1);
          end
        end
        SEND: begin
          if (w_hs) begin
            if (w_load) begin
              r_shift  <= w_load_blk;
              r_last   <= w_load_last;
              r_cnt    <= '0;
              r_tlast  <= w_load_last && (NWORDS == 1);
            end else if (w_final) begin
              r_state  <= IDLE;
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_shift  <= r_shift << WORD_BITS;
              r_cnt    <= r_cnt + CNT_W'(1);
              r_tlast  <= r_last && (r_cnt == CNT_W'(NWORDS - 2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so only a push with no pop on a full FIFO is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_afull    <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      r_afull <= ((FIFO_DEPTH - int'(w_count_next)) <= AFULL_MARGIN);
    end
  end

  assign in_afull      = r_afull;
  assign overflow      = r_overflow;
  assign fifo_count    = w_count;
  assign m_axis_tdata  = r_shift[BLK_BITS-1 -: WORD_BITS];
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;

endmodule

// File: tb/tb_gcm_out_serializer.sv
// Bench for gcm_out_serializer: occupancy model feeds an expected-word queue,
// an independent monitor pops and compares on every AXIS handshake.
module tb_gcm_out_serializer;
  import gcm_pkg::*;

  localparam int BLK    = 128;
  localparam int WB     = 32;
  localparam int NW     = BLK / WB;
  localparam int DEPTH  = 4;
  localparam int MARGIN = 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [BLK-1:0] in_blk;
  logic           in_store;
  logic           in_last;
  logic           in_afull;
  logic           overflow;
  logic [CW-1:0]  fifo_count;
  logic [WB-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;

  always #5 clk = ~clk;

  gcm_out_serializer #(
    .BLK_BITS     (BLK),
    .WORD_BITS    (WB),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_MARGIN (MARGIN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_blk        (in_blk),
    .in_store      (in_store),
    .in_last       (in_last),
    .in_afull      (in_afull),
    .overflow      (overflow),
    .fifo_count    (fifo_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [WB-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];

  // Model state in terms of occupancy only: is a block being sent, which word, how many queued.
  bit m_active;
  int m_widx;
  int m_fifo_n;
  bit m_ovf;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_widx   = 0;
      m_fifo_n = 0;
      m_ovf    = 1'b0;
      exp_q.delete();
    end else begin
      bit fin, slot, pop, byp, take;
      int n_before;
      chk("tvalid", m_axis_tvalid, m_active);
      chk("fifo_count", fifo_count, m_fifo_n);
      chk("overflow", overflow, m_ovf);
      chk("in_afull", in_afull, (DEPTH - m_fifo_n) <= MARGIN);

      n_before = m_fifo_n;
      fin  = m_active && m_axis_tready && (m_widx == NW - 1);
      slot = !m_active || fin;
      pop  = slot && (n_before > 0);
      byp  = slot && (n_before == 0) && in_store;
      take = byp;
      if (m_active && m_axis_tready && !fin) m_widx++;
      if (pop) begin
        m_active = 1'b1; m_widx = 0; m_fifo_n--;
      end else if (byp) begin
        m_active = 1'b1; m_widx = 0;
      end else if (fin) begin
        m_active = 1'b0;
      end
      if (in_store && !byp) begin
        if (n_before < DEPTH || pop) begin
          m_fifo_n++;
          take = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (take) begin
        for (int w = 0; w < NW; w++)
          exp_q.push_back('{in_blk[BLK-1-w*WB -: WB], in_last && (w == NW - 1)});
      end
    end
  end

  bit            prev_stall;
  logic [WB-1:0] prev_data;
  logic          prev_last;
  int            tlast_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1'b1);
        chk("stall_tdata", m_axis_tdata, prev_data);
        chk("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (m_axis_tlast) tlast_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word got %0h expected none at %0t", m_axis_tdata, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("tdata", m_axis_tdata, e.data);
          chk("tlast", m_axis_tlast, e.last);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  bit rand_ready = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_blk(input logic [BLK-1:0] blk, input logic last);
    in_blk   = blk;
    in_last  = last;
    in_store = 1'b1;
    tick();
    in_store = 1'b0;
    in_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_store = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_last = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  function automatic logic [BLK-1:0] pattern(input int b);
    logic [BLK-1:0] v;
    for (int w = 0; w < NW; w++) v[BLK-1-w*WB -: WB] = 32'h1000_0000 + 32'(b * NW + w);
    return v;
  endfunction

  logic [WB-1:0] msg_w [8] = '{32'h0388dace, 32'h60b6a392, 32'hf328c2b9, 32'h71b2fe78,
                               32'hab6e47d4, 32'h2cec13bd, 32'hf53a67b2, 32'h1257bddf};
  localparam logic [BLK-1:0] DATA_BLK = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [BLK-1:0] TAG_BLK  = 128'hab6e47d42cec13bdf53a67b21257bddf;

  initial begin
    int tl0;
    reset         = 1'b1;
    in_store      = 1'b0;
    in_last       = 1'b0;
    in_blk        = '0;
    m_axis_tready = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_count", fifo_count, '0);
    chk("rst_afull", in_afull, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    idle(2);

    // Single block, streaming sink
    m_axis_tready = 1'b1;
    send_blk(DATA_BLK, 1'b0);
    for (int k = 0; k < NW; k++) begin
      chk("single_tvalid", m_axis_tvalid, 1'b1);
      chk("single_word", m_axis_tdata, msg_w[k]);
      chk("single_tlast", m_axis_tlast, 1'b0);
      tick();
    end
    chk("single_done", m_axis_tvalid, 1'b0);
    idle(3);

    // Data block then tag one cycle later: eight contiguous words
    send_blk(DATA_BLK, 1'b0);
    send_blk(TAG_BLK, 1'b1);
    for (int k = 1; k < 8; k++) begin
      chk("msg_tvalid", m_axis_tvalid, 1'b1);
      chk("msg_word", m_axis_tdata, msg_w[k]);
      chk("msg_tlast", m_axis_tlast, k == 7);
      tick();
    end
    idle(4);

    // Backpressure: one bypass plus four queued blocks
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_blk(pattern(100 + i), i == 5);
      chk("bp_afull", in_afull, (i - 1) >= 3);
    end
    chk("bp_count", fifo_count, 4);
    chk("bp_ovf", overflow, 1'b0);
    idle(2);
    m_axis_tready = 1'b1;
    idle(25);

    // Overflow: sixth block with the sink stalled is dropped
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 6; i++) send_blk(pattern(200 + i), i == 5);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", fifo_count, 4);
    idle(3);
    m_axis_tready = 1'b1;
    idle(30);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset after two words of a block
    send_blk(pattern(300), 1'b1);
    idle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_tvalid", m_axis_tvalid, 1'b0);
    chk("rstmid_count", fifo_count, '0);
    chk("rstmid_ovf", overflow, 1'b0);
    send_blk(pattern(400), 1'b0);
    chk("rstmid_word0", m_axis_tdata, 32'h1000_0000 + 32'(400 * NW));
    idle(8);

    // Random sink readiness, sixteen blocks, tag on every fourth
    tl0 = tlast_seen;
    rand_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      send_blk(pattern(b), (b % 4) == 3);
      idle($urandom_range(6, 12));
    end
    idle(60);
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    idle(20);
    chk("rand_tlast_count", tlast_seen - tl0, 4);
    chk("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
